ignition_sequencer: RTL
=======================

# ignition_sequencer

Clocked start/stop controller that sequences the vehicle from key-off through accessory, pre-start check, crank and run. It consumes `START_PERMIT`, `WARN_PRI1` and `WARN_PRI2` from the combinational `vehicle_safety` block and drives the starter, ignition and accessory enables plus a timed chime pattern. It is the sequential layer that turns the safety interlock into an actual start procedure.

## Interface

Parameters:
- `CHECK_CYCLES`, default 16: cycles `START_PERMIT` must be held before crank (1..65535).
- `CRANK_MAX`, default 64: maximum crank cycles before fault (1..65535).
- `CHIME_ON`, default 8: chime high cycles per burst (1..255).
- `CHIME_OFF`, default 8: chime low cycles per burst (1..255).
- `CHIME_BURSTS`, default 6: on/off periods per triggered chime (1..15).

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `KEY`  in  1  key present / ignition switch on.
- `START_BTN`  in  1  start/stop pushbutton level, already synchronised.
- `BRK`  in  1  brake pedal pressed.
- `START_PERMIT`  in  1  from `vehicle_safety`.
- `WARN_PRI1`  in  1  critical warning from `vehicle_safety`.
- `WARN_PRI2`  in  1  non-critical warning from `vehicle_safety`.
- `ENG_RUN`  in  1  engine-running feedback.
- `SRV`  in  1  service mode; masks `CHIME_OUT` only.
- `ACC_EN`  out  1  accessory power.
- `IGN_ON`  out  1  ignition on.
- `CRANK_EN`  out  1  starter motor drive.
- `CHIME_OUT`  out  1  chime drive.
- `FAULT`  out  1  start/stall fault latched.
- `STATE`  out  3  current state encoding, for debug.

## Operation

- States: `OFF`=0, `ACC`=1, `CHECK`=2, `CRANK`=3, `RUN`=4, `FAULT`=5. Codes 6–7 return to `OFF` on the next edge.
- `btn_rise` = `START_BTN` & ~registered previous `START_BTN` (register resets to 0).
- `KEY`=0 in any state forces `OFF` on the next edge. This has the highest priority.
- `OFF`: `KEY`=1 → `ACC`.
- `ACC`: `btn_rise` & `BRK` → `CHECK`; the counter loads `CHECK_CYCLES`-1. `btn_rise` without `BRK` → stay in `ACC` and trigger chime.
- `CHECK`: `START_PERMIT`=0 on any cycle → `ACC` and trigger chime. Otherwise, the counter decrements, and on the cycle it equals 0 the next state is `CRANK`; the counter loads `CRANK_MAX`-1.
- `CRANK`: `ENG_RUN`=1 → `RUN`. Else `WARN_PRI1`=1 → `ACC` and trigger chime. Else counter=0 → `FAULT`. Else decrement. `ENG_RUN` wins over timeout on the same cycle.
- `RUN`: `btn_rise` → `ACC` (engine stop). `ENG_RUN`=0 → `FAULT` (stall). `btn_rise` wins.
- `FAULT`: exits only via `KEY`=0.
- Moore outputs, decoded from the state register:
  - `ACC_EN`=1 in every state except `OFF`.
  - `IGN_ON`=1 in `CHECK`, `CRANK` and `RUN`.
  - `CRANK_EN`=1 in `CRANK` only.
  - `FAULT`=1 in `FAULT` only.
- Chime triggers: abort events above, entry into `FAULT`, and rising edge of `WARN_PRI2` while in `RUN`.
- Triggered chime: `CHIME_BURSTS` periods of `CHIME_ON` high then `CHIME_OFF` low. A retrigger during an active burst restarts the pattern from the first high cycle.
- Continuous chime: while in `FAULT`, or while in `RUN` with `WARN_PRI1`=1.
- `CHIME_OUT` = (pattern high | continuous) & ~`SRV`. Pattern counters keep running while `SRV`=1.

## Timing

- Reset: `STATE`=`OFF`, all outputs 0, counters 0, chime idle, button-edge register 0.
- All outputs are registered. A transition condition sampled at edge k makes the new state and its outputs visible after edge k.
- `CHECK` lasts exactly `CHECK_CYCLES` cycles when permit is held. `CRANK` lasts at most `CRANK_MAX` cycles.
- Chime pattern: the first high cycle is the cycle after the trigger edge. Total length is `CHIME_BURSTS`×(`CHIME_ON`+`CHIME_OFF`) cycles, then idle.
- An async `rst` mid-crank drops `CRANK_EN` immediately, without waiting for a clock edge.
- A `KEY` drop mid-crank or mid-chime clears the state machine to `OFF` and cancels the pattern on the next edge.

## Structure

- Package `vehicle_pkg`: state encoding localparams, state width (3), default timing constants.
- One sub-module, `chime_gen`:
  - Inputs: `trigger`, `continuous`, `mask`.
  - Internals: on/off phase counter (8 bit) and burst counter (4 bit).
- The top level holds the FSM, the 16-bit sequencing counter and edge detection.

## Test plan

All scenarios use `CHECK_CYCLES`=4, `CRANK_MAX`=8, `CHIME_ON`=2, `CHIME_OFF`=2, `CHIME_BURSTS`=3.

- Normal start: `KEY`=1, `BRK`=1, `START_PERMIT`=1, pulse `START_BTN`; `ENG_RUN`=1 on the 3rd `CRANK` cycle. Required: `CHECK` for 4 cycles, `CRANK_EN` for 3 cycles, then `RUN` with `IGN_ON`=1.
- Permit loss: drop `START_PERMIT` in `CHECK` cycle 2. Required: → `ACC`, `CRANK_EN` never asserted, `CHIME_OUT` pattern 110011001100 then 0.
- Crank timeout: `ENG_RUN` held at 0. Required: `CRANK_EN` for exactly 8 cycles, then `FAULT`=1 with continuous chime. `KEY`=0 → `OFF`, all outputs 0.
- Stall and stop: in `RUN`, drop `ENG_RUN` → `FAULT`. Separate run: `btn_rise` in `RUN` → `ACC`, `IGN_ON`=0.
- Priority and masking: in `RUN`, `WARN_PRI2` rises with `SRV`=1. Required: `CHIME_OUT` stays 0, and after `SRV`=0 mid-pattern the remaining high phases appear.
- Reset mid-crank: assert `rst` between clock edges during `CRANK`. Required: `CRANK_EN`=0 immediately and `STATE`=0.

Source files
------------

// File: rtl/vehicle_pkg.sv
// -----------------------------------------------------------------------------
// vehicle_pkg
//
// Shared definitions for the ignition sequencing logic:
//   - state encoding of the start/stop state machine (3-bit, visible on STATE)
//   - widths of the sequencing and chime counters
//   - default timing constants used as module parameter defaults
//   - a small decode helper for the ignition-on state group
// -----------------------------------------------------------------------------
package vehicle_pkg;

    localparam int STATE_W = 3;

    // Codes 6 and 7 are unused; the FSM steers them back to ST_OFF.
    typedef enum logic [STATE_W-1:0] {
        ST_OFF   = 3'd0,
        ST_ACC   = 3'd1,
        ST_CHECK = 3'd2,
        ST_CRANK = 3'd3,
        ST_RUN   = 3'd4,
        ST_FAULT = 3'd5
    } state_e;

    localparam int SEQ_CNT_W     = 16;
    localparam int CHIME_PHASE_W = 8;
    localparam int CHIME_BURST_W = 4;

    localparam int CHECK_CYCLES_DEFAULT = 16;
    localparam int CRANK_MAX_DEFAULT    = 64;
    localparam int CHIME_ON_DEFAULT     = 8;
    localparam int CHIME_OFF_DEFAULT    = 8;
    localparam int CHIME_BURSTS_DEFAULT = 6;

    // Ignition is live whenever the engine is being checked, cranked or run.
    function automatic logic ign_active(input state_e s);
        return (s == ST_CHECK) || (s == ST_CRANK) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/chime_gen.sv
// -----------------------------------------------------------------------------
// chime_gen
//
// Chime pattern generator. A trigger starts CHIME_BURSTS periods of CHIME_ON
// high cycles followed by CHIME_OFF low cycles; the first high cycle is the
// cycle right after the triggering edge. A trigger during an active pattern
// restarts it. 'continuous' forces the output high, 'mask' forces it low
// without stopping the pattern counters, and 'cancel' aborts the pattern.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   trigger      start / restart the burst pattern on this edge
//   cancel       abort any running pattern on this edge (wins over trigger)
//   continuous   hold the chime on for the coming cycle
//   mask         silence the chime output for the coming cycle
//   chime        registered chime drive
// -----------------------------------------------------------------------------
module chime_gen
    import vehicle_pkg::*;
#(
    parameter int CHIME_ON     = CHIME_ON_DEFAULT,
    parameter int CHIME_OFF    = CHIME_OFF_DEFAULT,
    parameter int CHIME_BURSTS = CHIME_BURSTS_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic trigger,
    input  logic cancel,
    input  logic continuous,
    input  logic mask,
    output logic chime
);

    localparam logic [CHIME_PHASE_W-1:0] ON_LOAD    = CHIME_PHASE_W'(CHIME_ON - 1);
    localparam logic [CHIME_PHASE_W-1:0] OFF_LOAD   = CHIME_PHASE_W'(CHIME_OFF - 1);
    localparam logic [CHIME_BURST_W-1:0] BURST_LOAD = CHIME_BURST_W'(CHIME_BURSTS - 1);

    logic                     active, active_n;
    logic                     high, high_n;
    logic [CHIME_PHASE_W-1:0] phase, phase_n;
    logic [CHIME_BURST_W-1:0] burst, burst_n;

    // 'phase' counts down the cycles left in the current high/low phase,
    // 'burst' counts down the on/off periods still to come after this one.
    always_comb begin
        // NOTE: every variable gets a default before any branch, otherwise
        // a missed path would infer a latch.
        active_n = active;
        high_n   = high;
        phase_n  = phase;
        burst_n  = burst;

        if (cancel) begin
            active_n = 1'b0;
            high_n   = 1'b0;
            phase_n  = '0;
            burst_n  = '0;
        end else if (trigger) begin
            active_n = 1'b1;
            high_n   = 1'b1;
            phase_n  = ON_LOAD;
            burst_n  = BURST_LOAD;
        end else if (active) begin
            if (phase != '0) begin
                phase_n = phase - 1'b1;
            end else if (high) begin
                high_n  = 1'b0;
                phase_n = OFF_LOAD;
            end else if (burst != '0) begin
                burst_n = burst - 1'b1;
                high_n  = 1'b1;
                phase_n = ON_LOAD;
            end else begin
                active_n = 1'b0;
            end
        end
    end

    // The output register is fed from the next pattern state so that the
    // first high cycle appears immediately after the trigger edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            high   <= 1'b0;
            phase  <= '0;
            burst  <= '0;
            chime  <= 1'b0;
        end else begin
            // NOTE: registered state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            active <= active_n;
            high   <= high_n;
            phase  <= phase_n;
            burst  <= burst_n;
            chime  <= ((active_n & high_n) | continuous) & ~mask;
        end
    end

endmodule

// File: rtl/ignition_sequencer.sv
// -----------------------------------------------------------------------------
// ignition_sequencer
//
// Start/stop controller: OFF -> ACC -> CHECK -> CRANK -> RUN, with FAULT for
// crank timeout and stall. Removing the key returns to OFF from anywhere.
// Abort events, FAULT entry and a WARN_PRI2 rise in RUN trigger a chime
// pattern; FAULT and RUN with WARN_PRI1 hold the chime on continuously.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   KEY            key present / ignition switch on
//   START_BTN      start/stop pushbutton level (synchronised)
//   BRK            brake pedal pressed
//   START_PERMIT   start interlock from vehicle_safety
//   WARN_PRI1      critical warning from vehicle_safety
//   WARN_PRI2      non-critical warning from vehicle_safety
//   ENG_RUN        engine-running feedback
//   SRV            service mode, silences CHIME_OUT only
//   ACC_EN         accessory power (all states but OFF)
//   IGN_ON         ignition on (CHECK, CRANK, RUN)
//   CRANK_EN       starter motor drive (CRANK)
//   CHIME_OUT      chime drive
//   FAULT          start/stall fault (FAULT state)
//   STATE          current state code for debug
// -----------------------------------------------------------------------------
module ignition_sequencer
    import vehicle_pkg::*;
#(
    parameter int CHECK_CYCLES = CHECK_CYCLES_DEFAULT,
    parameter int CRANK_MAX    = CRANK_MAX_DEFAULT,
    parameter int CHIME_ON     = CHIME_ON_DEFAULT,
    parameter int CHIME_OFF    = CHIME_OFF_DEFAULT,
    parameter int CHIME_BURSTS = CHIME_BURSTS_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               KEY,
    input  logic               START_BTN,
    input  logic               BRK,
    input  logic               START_PERMIT,
    input  logic               WARN_PRI1,
    input  logic               WARN_PRI2,
    input  logic               ENG_RUN,
    input  logic               SRV,
    output logic               ACC_EN,
    output logic               IGN_ON,
    output logic               CRANK_EN,
    output logic               CHIME_OUT,
    output logic               FAULT,
    output logic [STATE_W-1:0] STATE
);

    localparam logic [SEQ_CNT_W-1:0] CHECK_LOAD = SEQ_CNT_W'(CHECK_CYCLES - 1);
    localparam logic [SEQ_CNT_W-1:0] CRANK_LOAD = SEQ_CNT_W'(CRANK_MAX - 1);

    state_e               state, state_n;
    logic [SEQ_CNT_W-1:0] cnt, cnt_n;
    logic                 btn_q, warn2_q;
    logic                 btn_rise, warn2_rise;
    logic                 chime_trig, chime_cont;

    assign btn_rise   = START_BTN & ~btn_q;
    assign warn2_rise = WARN_PRI2 & ~warn2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_OFF;
            cnt     <= '0;
            btn_q   <= 1'b0;
            warn2_q <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            btn_q   <= START_BTN;
            warn2_q <= WARN_PRI2;
        end
    end

    // 'cnt' holds the cycles remaining in CHECK or CRANK; the state exits
    // on the cycle it reads zero, so a load of N-1 gives exactly N cycles.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        chime_trig = 1'b0;

        if (!KEY) begin
            state_n = ST_OFF;
            cnt_n   = '0;
        end else begin
            case (state)
                ST_OFF: state_n = ST_ACC;

                ST_ACC: begin
                    if (btn_rise) begin
                        if (BRK) begin
                            state_n = ST_CHECK;
                            cnt_n   = CHECK_LOAD;
                        end else begin
                            chime_trig = 1'b1;
                        end
                    end
                end

                ST_CHECK: begin
                    if (!START_PERMIT) begin
                        state_n    = ST_ACC;
                        chime_trig = 1'b1;
                    end else if (cnt == '0) begin
                        state_n = ST_CRANK;
                        cnt_n   = CRANK_LOAD;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end

                // Engine feedback is checked first so a start on the very
                // last crank cycle still counts as a start.
                ST_CRANK: begin
                    if (ENG_RUN) begin
                        state_n = ST_RUN;
                    end else if (WARN_PRI1) begin
                        state_n    = ST_ACC;
                        chime_trig = 1'b1;
                    end else if (cnt == '0) begin
                        state_n    = ST_FAULT;
                        chime_trig = 1'b1;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end

                // A deliberate stop beats stall detection: the driver
                // pressing stop as the engine dies is not a fault.
                ST_RUN: begin
                    if (btn_rise) begin
                        state_n = ST_ACC;
                    end else if (!ENG_RUN) begin
                        state_n    = ST_FAULT;
                        chime_trig = 1'b1;
                    end
                    if (warn2_rise) begin
                        chime_trig = 1'b1;
                    end
                end

                ST_FAULT: state_n = ST_FAULT;

                default: state_n = ST_OFF;
            endcase
        end

        // Continuous chime follows the state being entered so it lines up
        // with the registered Moore outputs of that state.
        chime_cont = (state_n == ST_FAULT) || ((state_n == ST_RUN) && WARN_PRI1);
    end

    chime_gen #(
        .CHIME_ON     (CHIME_ON),
        .CHIME_OFF    (CHIME_OFF),
        .CHIME_BURSTS (CHIME_BURSTS)
    ) u_chime (
        .clk        (clk),
        .rst        (rst),
        .trigger    (chime_trig),
        .cancel     (~KEY),
        .continuous (chime_cont),
        .mask       (SRV),
        .chime      (CHIME_OUT)
    );

    // Decoded straight from the state register: no input reaches these
    // outputs combinationally, and an async reset clears them at once.
    assign ACC_EN   = (state != ST_OFF);
    assign IGN_ON   = ign_active(state);
    assign CRANK_EN = (state == ST_CRANK);
    assign FAULT    = (state == ST_FAULT);
    assign STATE    = state;

endmodule
